// File: rtl/dvi_pkg.sv
// Shared DVI constants: 640x480@60 timing, TMDS symbols.
// Helper to sum the four segments of a line or frame.
package dvi_pkg;

  localparam int DVI_H_ACTIVE = 640;
  localparam int DVI_H_FP     = 16;
  localparam int DVI_H_SYNC   = 96;
  localparam int DVI_H_BP     = 48;
  localparam int DVI_V_ACTIVE = 480;
  localparam int DVI_V_FP     = 10;
  localparam int DVI_V_SYNC   = 2;
  localparam int DVI_V_BP     = 33;

  localparam logic [9:0] SYM_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] SYM_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] SYM_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] SYM_CTRL_11 = 10'b1010101011;

  localparam logic [7:0] SYM_PIX_OFF = 8'h00;
  localparam logic [7:0] SYM_PIX_ON  = 8'hFF;

  function automatic int dvi_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Pixel-side bus of the timing generator:
// fetch request/answer plus encoder outputs.
interface dvi_timing_gen_if #(
  parameter int CNT_W = 11
);

  logic             o_req;
  logic [CNT_W-1:0] o_x;
  logic [CNT_W-1:0] o_y;
  logic             i_pix;
  logic             o_pix;
  logic             o_de;
  logic             o_hs;
  logic             o_vs;
  logic             o_frame_start;

  modport master (
    output o_req,
    output o_x,
    output o_y,
    input  i_pix,
    output o_pix,
    output o_de,
    output o_hs,
    output o_vs,
    output o_frame_start
  );

  modport slave (
    input  o_req,
    input  o_x,
    input  o_y,
    output i_pix,
    input  o_pix,
    input  o_de,
    input  o_hs,
    input  o_vs,
    input  o_frame_start
  );

endinterface

// File: rtl/dvi_hv_counter.sv
// Free-running raster H/V counters.
// h wraps each line, v wraps each frame.
module dvi_hv_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CNT_W   = 11
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  // Next position: step h, carry into v at end of line
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Counter registers, restart at the top-left corner
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o = h_q;
  assign v_o = v_q;

endmodule

// File: rtl/dvi_timing_gen.sv
// Raster timing generator for the TMDS encoder.
// DVI_TIMING_TEST_PATTERN_EN: 8x8 checkerboard on o_pix.
module dvi_timing_gen
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = DVI_H_ACTIVE,
  parameter int H_FP     = DVI_H_FP,
  parameter int H_SYNC   = DVI_H_SYNC,
  parameter int H_BP     = DVI_H_BP,
  parameter int V_ACTIVE = DVI_V_ACTIVE,
  parameter int V_FP     = DVI_V_FP,
  parameter int V_SYNC   = DVI_V_SYNC,
  parameter int V_BP     = DVI_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  dvi_timing_gen_if.master  bus
);

  localparam int H_TOTAL =
    dvi_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    dvi_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT =
    CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT =
    CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h, v;
  logic             req;

  logic de_q, de_d;
  logic pix_q, pix_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic fs_q, fs_d;

  dvi_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk_i  (i_clk),
    .rstn_i (i_rstn),
    .h_o    (h),
    .v_o    (v)
  );

  assign req = (h < H_ACT) && (v < V_ACT);

  // Stage-1 values computed from the current raster position
  always_comb begin
    de_d = req;
    fs_d = (h == '0) && (v == '0);
    hs_d = ((h >= HS_BEG) && (h < HS_END))
         ? HS_POL : ~HS_POL;
    vs_d = ((v >= VS_BEG) && (v < VS_END))
         ? VS_POL : ~VS_POL;
`ifdef DVI_TIMING_TEST_PATTERN_EN
    pix_d = req & (h[3] ^ v[3]);
`else
    pix_d = req & bus.i_pix;
`endif
  end

  // Output register stage, idle levels under reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      de_q  <= 1'b0;
      pix_q <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      de_q  <= de_d;
      pix_q <= pix_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign bus.o_req         = req;
  assign bus.o_x           = h;
  assign bus.o_y           = v;
  assign bus.o_de          = de_q;
  assign bus.o_pix         = pix_q;
  assign bus.o_hs          = hs_q;
  assign bus.o_vs          = vs_q;
  assign bus.o_frame_start = fs_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen on a tiny 8x6 raster.
// Reference derives everything from the cycle index.
module tb_dvi_timing_gen;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  dvi_timing_gen_if #(.CNT_W(CW)) bus();

  dvi_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .HS_POL   (1'b0),
    .VS_POL   (1'b0),
    .CNT_W    (CW)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  int edges = 0;
  int last_fs = -1;
  int de_cnt, hs_cnt, vs_cnt, fs_cnt, blank_pix;

  function automatic int hpos(input int k);
    return k % HT;
  endfunction

  function automatic int vpos(input int k);
    return (k / HT) % VT;
  endfunction

  function automatic bit act(input int k);
    return (hpos(k) < HA) && (vpos(k) < VA);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    de_cnt = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    fs_cnt = 0;
    blank_pix = 0;
  endtask

  // mode 0: random data, 1: x[0]^y[0], 2: constant 1
  task automatic step(input bit rst, input int mode);
    bit p;
    int k;
    bit e_de, e_pix, e_hs, e_vs, e_fs;
    case (mode)
      0: p = 1'($urandom_range(0, 1));
      1: p = bus.o_x[0] ^ bus.o_y[0];
      default: p = 1'b1;
    endcase
    bus.i_pix = p;
    rstn = ~rst;
    k = n;
    @(posedge clk);
    #1;
    edges++;
    if (rst) begin
      n = 0;
      last_fs = -1;
      e_de = 0; e_pix = 0; e_fs = 0;
      e_hs = 1; e_vs = 1;
    end else begin
      n = k + 1;
      e_de = act(k);
`ifdef DVI_TIMING_TEST_PATTERN_EN
      e_pix = act(k) &
        1'(((hpos(k) >> 3) ^ (vpos(k) >> 3)) & 1);
`else
      e_pix = act(k) & p;
`endif
      e_hs = !(hpos(k) >= HA + HF &&
               hpos(k) < HA + HF + HS);
      e_vs = !(vpos(k) >= VA + VF &&
               vpos(k) < VA + VF + VS);
      e_fs = (k % FT) == 0;
    end
    chk("req", 32'(bus.o_req), 32'(act(n)));
    chk("x", 32'(bus.o_x), hpos(n));
    chk("y", 32'(bus.o_y), vpos(n));
    chk("de", 32'(bus.o_de), 32'(e_de));
    chk("pix", 32'(bus.o_pix), 32'(e_pix));
    chk("hs", 32'(bus.o_hs), 32'(e_hs));
    chk("vs", 32'(bus.o_vs), 32'(e_vs));
    chk("fs", 32'(bus.o_frame_start), 32'(e_fs));
    if (bus.o_de === 1'b1) de_cnt++;
    if (bus.o_hs === 1'b0) hs_cnt++;
    if (bus.o_vs === 1'b0) vs_cnt++;
    if (bus.o_pix === 1'b1 && bus.o_de !== 1'b1)
      blank_pix++;
    if (bus.o_frame_start === 1'b1) begin
      fs_cnt++;
      if (last_fs >= 0)
        chk("fs_gap", edges - last_fs, FT);
      last_fs = edges;
    end
  endtask

  initial begin
    logic q[$];
    bit   exp8[8];
    int   guard;
    bus.i_pix = 1'b0;

    // 1: reset, then release
    for (int i = 0; i < 3; i++) step(1, 0);
    chk("rst_req", 32'(bus.o_req), 1);
    chk("rst_xy", {bus.o_x, bus.o_y}, 0);
    step(0, 0);
    chk("rel_de", 32'(bus.o_de), 1);
    chk("rel_fs", 32'(bus.o_frame_start), 1);

    // 2: remainder of line 0
    clear_counts();
    de_cnt = 1;
    for (int i = 0; i < 7; i++) step(0, 0);
    chk("line_de", de_cnt, HA);
    chk("line_hs", hs_cnt, HS);
    chk("wrap_x", 32'(bus.o_x), 0);
    chk("wrap_y", 32'(bus.o_y), 1);

    // 3: two full frames of random data
    clear_counts();
    for (int i = 0; i < 2 * FT; i++) step(0, 0);
    chk("frm_de", de_cnt, 2 * HA * VA);
    chk("frm_vs", vs_cnt, 2 * HT * VS);
    chk("frm_fs", fs_cnt, 2);

    // 4: upstream answers x[0]^y[0]
    for (int i = 0; i < 2; i++) step(1, 0);
    q.delete();
    for (int i = 0; i < 2 * HT; i++) begin
      step(0, 1);
      if (bus.o_de === 1'b1) q.push_back(bus.o_pix);
    end
`ifdef DVI_TIMING_TEST_PATTERN_EN
    exp8 = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp8 = '{0, 1, 0, 1, 1, 0, 1, 0};
`endif
    chk("xy_len", q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q.size())
        chk("xy_pix", 32'(q[i]), 32'(exp8[i]));
    clear_counts();
    for (int i = 0; i < FT; i++) step(0, 2);
    chk("blank_pix", blank_pix, 0);

    // 5: reset mid-frame at h=3, v=2
    guard = 0;
    while (!(hpos(n) == 3 && vpos(n) == 2) &&
           guard < 4 * FT) begin
      step(0, 0);
      guard++;
    end
    chk("mid_reach", 32'(hpos(n) == 3 && vpos(n) == 2), 1);
    step(1, 0);
    chk("mid_de", 32'(bus.o_de), 0);
    chk("mid_hs", 32'(bus.o_hs), 1);
    chk("mid_vs", 32'(bus.o_vs), 1);
    chk("mid_xy", {bus.o_x, bus.o_y}, 0);
    clear_counts();
    for (int i = 0; i < FT; i++) step(0, 0);
    chk("mid_hs_cnt", hs_cnt, HS * VT);
    chk("mid_vs_cnt", vs_cnt, HT * VS);

    // random run with sporadic resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 39) == 0,
           int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
